// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: state encoding and counter sizing shared by the dmem_resp slice.
package dmem_resp_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/dmem_resp_if.sv
// dmem_resp_if: request/response handshake bundle between an initiator and dmem_resp.
interface dmem_resp_if;

  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_ready;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: 2^DEPTH_LOG2 x 32 storage, synchronous write, asynchronous read, no reset.
module dmem_ram #(
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Word write on the rising edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Combinational read of the addressed word.
  always_comb begin
    rdata = mem[addr];
  end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: single-outstanding data memory responder with programmable wait states.
// Optional build macro DMEM_RESP_ALIGN_CHECK_EN: flag misaligned accesses via rsp_err,
// suppress their store and zero their load data.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 5,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         pcrst,
  dmem_resp_if.slave   bus
);

  localparam cnt_t CNT_LOAD = (WAIT_CYCLES > 0) ? cnt_t'(WAIT_CYCLES - 1) : '0;

  state_t                state;
  state_t                state_nxt;
  cnt_t                  cnt;

  logic                  hold_we;
  logic [DEPTH_LOG2-1:0] hold_idx;
  logic [31:0]           hold_wdata;
  logic                  hold_mis;

  logic                  req_mis;
  logic                  accept;
  logic                  enter_resp;
  logic                  cur_we;
  logic                  cur_mis;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [31:0]           cur_wdata;

  logic                  ram_we;
  logic [31:0]           ram_rdata;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  unused_addr;

  // Misalignment detection (build-time optional).
  always_comb begin
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    req_mis = |bus.req_addr[1:0];
`else
    req_mis = 1'b0;
`endif
    unused_addr = ^{bus.req_addr[31:DEPTH_LOG2+2], bus.req_addr[1:0]};
  end

  // Accept/commit strobes and the transaction currently heading into RESP.
  // With zero wait states the commit edge is the accept edge, so the live
  // request fields are used instead of the held copies.
  always_comb begin
    accept     = (state == IDLE) && bus.req_valid;
    enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == '0));
    if (state == IDLE) begin
      cur_we    = bus.req_we;
      cur_mis   = req_mis;
      cur_idx   = bus.req_addr[DEPTH_LOG2+1:2];
      cur_wdata = bus.req_wdata;
    end else begin
      cur_we    = hold_we;
      cur_mis   = hold_mis;
      cur_idx   = hold_idx;
      cur_wdata = hold_wdata;
    end
    ram_we = enter_resp && cur_we && !cur_mis && pcrst;
  end

  dmem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge pcrst) begin
    if (!pcrst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0)     state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk or negedge pcrst) begin
    if (!pcrst) begin
      cnt        <= '0;
      hold_we    <= 1'b0;
      hold_idx   <= '0;
      hold_wdata <= '0;
      hold_mis   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        hold_we    <= bus.req_we;
        hold_idx   <= bus.req_addr[DEPTH_LOG2+1:2];
        hold_wdata <= bus.req_wdata;
        hold_mis   <= req_mis;
        cnt        <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_resp) begin
        rdata_q <= (cur_we || cur_mis) ? '0 : ram_rdata;
        err_q   <= cur_mis;
      end
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

endmodule
